coax_queued_tx: RTL and testbench
=================================

COAX_QUEUED_TX -- requirements
Module: coax_queued_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, word width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in words; power of two, >=2.
REQ-003 SHALL have parameter AUTO_THRESHOLD, default 8, fill level that triggers auto-start; range 1..DEPTH.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data  input  DATA_WIDTH  word to enqueue.
REQ-007 SHALL have port load_strobe  input  1  enqueue data this cycle.
REQ-008 SHALL have port start_strobe  input  1  begin transmitting queued words as one message.
REQ-009 SHALL have port abort_strobe  input  1  flush queue, end message.
REQ-010 SHALL have port tx_data  output  DATA_WIDTH  head word to serializer.
REQ-011 SHALL have port tx_last  output  1  tx_data is the final word of the message.
REQ-012 SHALL have port tx_valid  output  1  tx_data/tx_last valid.
REQ-013 SHALL have port tx_ready  input  1  serializer accepts word.
REQ-014 SHALL have port tx_busy  input  1  serializer still shifting.
REQ-015 SHALL have port active  output  1  message in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at message end.
REQ-017 SHALL have ports full, empty  output  1 each  FIFO status.
REQ-018 SHALL have port level  output  $clog2(DEPTH)+1  words held, 0..DEPTH.
REQ-019 SHALL have port overflow  output  1  sticky: load dropped while full.

Function
REQ-020 SHALL implement states IDLE, SEND, FLUSH.
REQ-021 In IDLE, start_strobe with level>0 SHALL enter SEND; start_strobe with level=0 SHALL be ignored (no done).
REQ-022 In SEND, tx_valid SHALL be 1 whenever level>0; tx_data SHALL equal the oldest word.
REQ-023 Transfer SHALL occur on a cycle with tx_valid=1 and tx_ready=1; transfer pops one word.
REQ-024 tx_last SHALL be 1 when level=1 and load_strobe=0 that cycle.
REQ-025 Transfer with tx_last=1 SHALL move SEND->FLUSH; tx_valid SHALL be 0 in FLUSH and IDLE.
REQ-026 In FLUSH, first cycle with tx_busy=0 SHALL pulse done for one cycle and return to IDLE.
REQ-027 active SHALL be 1 in SEND and FLUSH, 0 in IDLE.
REQ-028 Latency: start_strobe at cycle n SHALL give tx_valid=1 at n+1.
REQ-029 load_strobe with full=0 SHALL enqueue in any state; words loaded during SEND before the tx_last transfer join the same message.
REQ-030 load_strobe with full=1 SHALL drop the word and set overflow, even if a pop occurs the same cycle.
REQ-031 Simultaneous load and pop (not full) SHALL leave level unchanged.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH; full=(level=DEPTH), empty=(level=0).
REQ-033 abort_strobe in any state SHALL set level to 0, go to IDLE, drop same-cycle load, give no done pulse; overflow unaffected.
REQ-034 start_strobe in SEND/FLUSH SHALL be ignored.

Reset
REQ-035 reset SHALL give state IDLE, pointers 0, level 0, empty 1, full 0, overflow 0, tx_valid 0, tx_last 0, tx_data 0, active 0, done 0.
REQ-036 reset mid-message SHALL discard queued words with no done pulse; reset takes priority over all strobes.

Configuration
REQ-037 With COAX_QUEUED_TX_AUTO_START_EN defined, IDLE with level>=AUTO_THRESHOLD SHALL enter SEND next cycle as if start_strobe.
REQ-038 Without COAX_QUEUED_TX_AUTO_START_EN, AUTO_THRESHOLD SHALL be ignored; only start_strobe starts.

Verification
REQ-039 DEPTH=8: load 0x175, 0x28E, 0x175, start, tx_ready=1, tx_busy=0 -> three transfers in order, tx_last on third only, then done pulse, level 0.
REQ-040 Load 9 words into DEPTH=8 -> full=1, level=8, overflow=1, ninth word never transmitted.
REQ-041 Start with 1 word, tx_ready=0 for 5 cycles -> tx_valid held, tx_data stable; load second word during stall -> tx_last moves to second word, message length 2.
REQ-042 After last transfer hold tx_busy=1 for 10 cycles -> active=1, done=0 until tx_busy falls, then done for exactly one cycle.
REQ-043 Abort after first of 3 transfers -> level 0, IDLE, tx_valid 0, no done pulse.
REQ-044 With COAX_QUEUED_TX_AUTO_START_EN, AUTO_THRESHOLD=4: load 4 words, no start -> tx_valid=1 the cycle after level reaches 4; without macro -> tx_valid stays 0.

Source files
------------

// File: rtl/coax_queued_tx.sv
`default_nettype none
// ============================================================================
//  Module      : coax_queued_tx
//  Description : Word FIFO feeding a serializer. Queued words are sent as one
//                message: tx_last marks the final word, then the block waits
//                for the serializer to go idle and pulses done.
//                Optional auto-start when the fill level reaches
//                AUTO_THRESHOLD is enabled by defining
//                COAX_QUEUED_TX_AUTO_START_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module coax_queued_tx #(
    parameter int DATA_WIDTH     = 10,
    parameter int DEPTH          = 16,
    parameter int AUTO_THRESHOLD = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    load_strobe,
    input  logic                    start_strobe,
    input  logic                    abort_strobe,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_last,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic                    tx_busy,
    output logic                    active,
    output logic                    done,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_LEVEL_W = c_ADDR_W + 1;

    // Reject parameter sets the pointer arithmetic cannot support.
    generate
        if ((DEPTH < 2) || ((1 << c_ADDR_W) != DEPTH) ||
            (AUTO_THRESHOLD < 1) || (AUTO_THRESHOLD > DEPTH)) begin : g_bad_params
            $error("coax_queued_tx: DEPTH must be a power of two >= 2 and AUTO_THRESHOLD in 1..DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_ADDR_W-1:0]    r_wr_ptr;
    logic [c_ADDR_W-1:0]    r_rd_ptr;
    logic [c_LEVEL_W-1:0]   r_level;
    logic                   r_overflow;
    logic                   r_done;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_full;
    logic                   w_empty;
    logic                   w_tx_valid;
    logic                   w_tx_last;
    logic                   w_xfer;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_auto;
    logic                   w_start;

    assign w_full     = (r_level == c_LEVEL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_tx_valid = (r_state == ST_SEND) && !w_empty;
    // A word arriving this cycle extends the message, so the head is only
    // final when nothing else is being loaded alongside it.
    assign w_tx_last  = w_tx_valid && (r_level == c_LEVEL_W'(1)) && !load_strobe;
    assign w_xfer     = w_tx_valid && tx_ready;
    assign w_push     = load_strobe && !w_full && !abort_strobe;
    assign w_pop      = w_xfer && !abort_strobe;

`ifdef COAX_QUEUED_TX_AUTO_START_EN
    assign w_auto     = (r_level >= c_LEVEL_W'(AUTO_THRESHOLD));
`else
    assign w_auto     = 1'b0;
`endif

    assign w_start    = (start_strobe && !w_empty) || w_auto;

    // Storage write; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // Pointer and fill-level bookkeeping; abort empties the queue outright.
    always_ff @(posedge clk) begin
        if (reset || abort_strobe) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LEVEL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LEVEL_W'(1);
            end
        end
    end

    // Sticky flag for any load refused because the queue was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (load_strobe && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Message sequencing: IDLE -> SEND until the last word leaves -> FLUSH
    // until the serializer drains, with done registered on the way out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort_strobe) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (w_xfer && w_tx_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                    ST_FLUSH: begin
                        if (!tx_busy) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign tx_valid = w_tx_valid;
    assign tx_last  = w_tx_last;
    assign tx_data  = w_tx_valid ? r_mem[r_rd_ptr] : '0;
    assign active   = (r_state != ST_IDLE);
    assign done     = r_done;
    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_coax_queued_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coax_queued_tx
//  Description : Scoreboard bench for coax_queued_tx with a queue-based
//                reference model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coax_queued_tx;

    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int THR   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data = '0;
    logic          load_strobe = 1'b0;
    logic          start_strobe = 1'b0;
    logic          abort_strobe = 1'b0;
    logic          tx_ready = 1'b0;
    logic          tx_busy = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_last;
    logic          tx_valid;
    logic          active;
    logic          done;
    logic          full;
    logic          empty;
    logic [3:0]    level;
    logic          overflow;

    coax_queued_tx #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEPTH),
        .AUTO_THRESHOLD (THR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .load_strobe  (load_strobe),
        .start_strobe (start_strobe),
        .abort_strobe (abort_strobe),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .active       (active),
        .done         (done),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard of words still owed to the serializer, oldest first.
    logic [DW-1:0] sb [$];

    // Reference model: queue occupancy, message phase (0 idle, 1 send,
    // 2 flush), sticky overflow, expected done and a just-reset marker.
    int mlevel = 0;
    int mphase = 0;
    bit movf   = 1'b0;
    bit mdone  = 1'b0;
    bit mrst   = 1'b1;
    bit m_xfer;
    bit m_last;
    bit m_auto;
    int m_old;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on every rising edge from the inputs the DUT sampled.
    always @(posedge clk) begin
        m_old  = mlevel;
        m_xfer = (mphase == 1) && (mlevel > 0) && tx_ready;
        m_last = m_xfer && (mlevel == 1) && !load_strobe;
`ifdef COAX_QUEUED_TX_AUTO_START_EN
        m_auto = (m_old >= THR);
`else
        m_auto = 1'b0;
`endif
        mdone = 1'b0;
        mrst  = reset;
        if (reset) begin
            mlevel = 0;
            mphase = 0;
            movf   = 1'b0;
            sb.delete();
        end else if (abort_strobe) begin
            if (load_strobe && (m_old == DEPTH)) movf = 1'b1;
            mlevel = 0;
            mphase = 0;
            sb.delete();
        end else begin
            if (load_strobe && (m_old == DEPTH)) begin
                movf = 1'b1;
            end else if (load_strobe) begin
                sb.push_back(data);
                mlevel++;
            end
            if (m_xfer) mlevel--;
            case (mphase)
                0: if ((start_strobe && m_old > 0) || m_auto) mphase = 1;
                1: if (m_last) mphase = 2;
                default: if (!tx_busy) begin
                    mphase = 0;
                    mdone  = 1'b1;
                end
            endcase
        end
    end

    // Monitor: compare status every cycle and each transferred word
    // against the scoreboard.
    logic [DW-1:0] exp_word;
    always @(negedge clk) begin
        check("level",    int'(level),    mlevel);
        check("full",     int'(full),     int'(mlevel == DEPTH));
        check("empty",    int'(empty),    int'(mlevel == 0));
        check("overflow", int'(overflow), int'(movf));
        check("active",   int'(active),   int'(mphase != 0));
        check("done",     int'(done),     int'(mdone));
        check("tx_valid", int'(tx_valid), int'((mphase == 1) && (mlevel > 0)));
        if (mrst) begin
            check("reset_tx_data", int'(tx_data), 0);
            check("reset_tx_last", int'(tx_last), 0);
        end
        if (tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL xfer_unexpected: got data %0h expected no transfer at %0t", tx_data, $time);
            end else begin
                exp_word = sb.pop_front();
                check("tx_data", int'(tx_data), int'(exp_word));
                check("tx_last", int'(tx_last), int'((mlevel == 1) && !load_strobe));
            end
        end
    end

    task automatic step(input bit ld, input logic [DW-1:0] d, input bit st,
                        input bit ab, input bit rdy, input bit bsy);
        load_strobe  = ld;
        data         = d;
        start_strobe = st;
        abort_strobe = ab;
        tx_ready     = rdy;
        tx_busy      = bsy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Three-word message, serializer always ready and idle.
        step(1, 10'h175, 0, 0, 1, 0);
        step(1, 10'h28E, 0, 0, 1, 0);
        step(1, 10'h175, 0, 0, 1, 0);
        step(0, '0, 1, 0, 1, 0);
        repeat (6) step(0, '0, 0, 0, 1, 0);

        // Start with an empty queue: ignored.
        step(0, '0, 1, 0, 1, 0);
        step(0, '0, 0, 0, 1, 0);

        // Nine loads into eight slots; ninth is dropped, then drain.
        for (int i = 0; i < 9; i++) step(1, DW'(10'h040 + i), 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        repeat (12) step(0, '0, 0, 0, 1, 0);

        // Stall with one word, second word joins during the stall.
        step(1, 10'h03A, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        repeat (4) step(0, '0, 0, 0, 0, 0);
        step(1, 10'h155, 0, 0, 0, 0);
        repeat (5) step(0, '0, 0, 0, 1, 0);

        // Serializer busy for a while after the last word.
        step(1, 10'h2AA, 0, 0, 0, 0);
        step(1, 10'h0F0, 0, 0, 0, 0);
        step(0, '0, 1, 0, 1, 1);
        repeat (12) step(0, '0, 0, 0, 1, 1);
        repeat (3) step(0, '0, 0, 0, 1, 0);

        // Abort after the first of three transfers.
        step(1, 10'h101, 0, 0, 0, 0);
        step(1, 10'h202, 0, 0, 0, 0);
        step(1, 10'h303, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        step(0, '0, 0, 0, 1, 0);
        step(0, '0, 0, 1, 0, 0);
        repeat (3) step(0, '0, 0, 0, 1, 0);

        // Reach the auto-start threshold without a start strobe.
        for (int i = 0; i < THR; i++) step(1, DW'(10'h011 * (i + 1)), 0, 0, 1, 0);
        repeat (3) step(0, '0, 0, 0, 1, 0);
        step(0, '0, 1, 0, 1, 0);
        repeat (8) step(0, '0, 0, 0, 1, 0);

        // Reset in the middle of a message.
        step(1, 10'h1C3, 0, 0, 0, 0);
        step(1, 10'h0C3, 0, 0, 0, 0);
        step(0, '0, 1, 0, 0, 0);
        reset = 1'b1;
        step(1, 10'h3FF, 1, 0, 1, 0);
        reset = 1'b0;
        repeat (2) step(0, '0, 0, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            automatic bit ab = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step(ab ? 1'b0 : ($urandom_range(0, 99) < 40),
                 DW'($urandom),
                 ($urandom_range(0, 99) < 15),
                 ab,
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 50));
        end
        reset = 1'b0;
        step(0, '0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
